// File: rtl/vldrdy_pkg.sv
// Shared types and constants for the valid/ready stream source.
// State encoding, data-pattern modes and Fibonacci LFSR tap masks per data width.
package vldrdy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    // Tap masks: bit k-1 set for tap k (8,6,5,4 and 16,14,13,11).
    localparam logic [7:0]  LFSR_TAPS8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS16 = 16'hB400;

endpackage

// File: rtl/vldrdy_pattern_gen.sv
// Data word register for the stream source: loads the seed on start, advances on each transfer.
// One-cycle latency from load/advance to data_o; holds its value whenever advance_i is low.
module vldrdy_pattern_gen
    import vldrdy_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [1:0]        mode_i,
    input  logic [DWIDTH-1:0] seed_i,
    input  logic              advance_i,
    output logic [DWIDTH-1:0] data_o
);
    localparam logic [DWIDTH-1:0] TAPS = (DWIDTH == 16) ? DWIDTH'(LFSR_TAPS16)
                                                        : DWIDTH'(LFSR_TAPS8);

    logic [1:0]        mode_q, mode_d;
    logic [DWIDTH-1:0] data_q, data_d;

    always_comb begin
        mode_d = mode_q;
        data_d = data_q;
        if (load_i) begin
            mode_d = mode_i;
            // An all-zero LFSR would lock up, so seed 0 starts from 1 instead.
            data_d = (mode_i == MODE_LFSR && seed_i == '0) ? DWIDTH'(1) : seed_i;
        end else if (advance_i) begin
            case (mode_q)
                MODE_LFSR:  data_d = {data_q[DWIDTH-2:0], ^(data_q & TAPS)};
                MODE_CONST: data_d = data_q;
                default:    data_d = data_q + DWIDTH'(1);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_INC;
            data_q <= '0;
        end else begin
            mode_q <= mode_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/master_vldrdy.sv
// Valid/ready stream source: sends cfg_len words with optional idle gaps, counts accepted words.
// All outputs registered; src_val/src_data hold through any src_rdy stall, cfg_en low freezes everything.
module master_vldrdy
    import vldrdy_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic              cfg_start,
    input  logic [CWIDTH-1:0] cfg_len,
    input  logic [1:0]        cfg_mode,
    input  logic [DWIDTH-1:0] cfg_seed,
    input  logic [1:0]        cfg_gap,
    output logic              src_val,
    input  logic              src_rdy,
    output logic [DWIDTH-1:0] src_data,
    output logic [CWIDTH-1:0] read_counter,
    output logic              busy,
    output logic              done
);
    state_t            state_q, state_d;
    logic [CWIDTH-1:0] len_q, len_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]        gap_q, gap_d;
    logic [1:0]        gcnt_q, gcnt_d;
    logic              val_q, val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer;
    logic              start;

    // A word offered before cfg_en dropped is still accepted on that edge.
    assign xfer  = val_q & src_rdy;
    assign start = cfg_en & cfg_start & ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        if (start) begin
            len_d   = cfg_len;
            gap_d   = cfg_gap;
            cnt_d   = '0;
            state_d = (cfg_len == '0) ? DONE : SEND;
        end else if (xfer) begin
            cnt_d = cnt_q + CWIDTH'(1);
            if (cnt_d == len_q) begin
                state_d = DONE;
            end else if (gap_q != 2'd0) begin
                state_d = GAP;
                gcnt_d  = gap_q - 2'd1;
            end
        end else if (cfg_en && state_q == GAP) begin
            if (gcnt_q == 2'd0) begin
                state_d = SEND;
            end else begin
                gcnt_d = gcnt_q - 2'd1;
            end
        end
        val_d  = cfg_en & (state_d == SEND);
        busy_d = (state_d == SEND) || (state_d == GAP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    vldrdy_pattern_gen #(
        .DWIDTH(DWIDTH)
    ) u_pattern_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (start),
        .mode_i   (cfg_mode),
        .seed_i   (cfg_seed),
        .advance_i(xfer),
        .data_o   (src_data)
    );

    assign src_val      = val_q;
    assign read_counter = cnt_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_master_vldrdy.sv
// Bench for master_vldrdy: 8-bit instance for stream/gap/stall/enable/reset cases,
// 16-bit instance for the LFSR sequence.
`timescale 1ns/1ps
module tb_master_vldrdy;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        en8, start8, rdy8, val8, busy8, done8;
    logic [9:0]  len8, cnt8;
    logic [1:0]  mode8, gap8;
    logic [7:0]  seed8, data8;

    // 16-bit instance
    logic        en16, start16, rdy16, val16, busy16, done16;
    logic [9:0]  len16, cnt16;
    logic [1:0]  mode16, gap16;
    logic [15:0] seed16, data16;

    master_vldrdy #(.DWIDTH(8), .CWIDTH(10)) dut8 (
        .clk(clk), .rst_n(rst_n), .cfg_en(en8), .cfg_start(start8), .cfg_len(len8),
        .cfg_mode(mode8), .cfg_seed(seed8), .cfg_gap(gap8), .src_val(val8), .src_rdy(rdy8),
        .src_data(data8), .read_counter(cnt8), .busy(busy8), .done(done8)
    );

    master_vldrdy #(.DWIDTH(16), .CWIDTH(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .cfg_en(en16), .cfg_start(start16), .cfg_len(len16),
        .cfg_mode(mode16), .cfg_seed(seed16), .cfg_gap(gap16), .src_val(val16), .src_rdy(rdy16),
        .src_data(data16), .read_counter(cnt16), .busy(busy16), .done(done16)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  q8[$];
    logic [15:0] q16[$];
    bit          seen16[logic [15:0]];

    typedef struct {
        logic [9:0]  len;
        logic [1:0]  mode;
        logic [7:0]  seed;
        logic [1:0]  gap;
        logic [15:0] vld;   // expected src_val per cycle after start, bit 0 first
        int          ncyc;  // cycles until done rises
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] nxt8(input logic [1:0] m, input logic [7:0] d);
        case (m)
            2'd1:    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
            2'd2:    return d;
            default: return d + 8'd1;
        endcase
    endfunction

    task automatic push8(input logic [9:0] len, input logic [1:0] mode, input logic [7:0] seed);
        logic [7:0] d;
        d = (mode == 2'd1 && seed == 8'd0) ? 8'h01 : seed;
        for (int i = 0; i < int'(len); i++) begin
            q8.push_back(d);
            d = nxt8(mode, d);
        end
    endtask

    task automatic push16_lfsr(input int len, input logic [15:0] seed);
        logic [15:0] d;
        d = (seed == 16'd0) ? 16'h0001 : seed;
        for (int i = 0; i < len; i++) begin
            q16.push_back(d);
            d = {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
        end
    endtask

    task automatic wait_done8(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!done8 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done8_wait", done8, 1'b1);
    endtask

    // Scoreboard monitors: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && val8 && rdy8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb8_unexpected: word %0h with nothing expected", data8);
            end else begin
                check("sb8_data", data8, q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && val16 && rdy16) begin
            check("lfsr16_repeat", seen16.exists(data16), 0);
            seen16[data16] = 1'b1;
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb16_unexpected: word %0h with nothing expected", data16);
            end else begin
                check("sb16_data", data16, q16.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        len8 = v.len; mode8 = v.mode; seed8 = v.seed; gap8 = v.gap;
        rdy8 = 1'b1; en8 = 1'b1;
        push8(v.len, v.mode, v.seed);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < v.ncyc; i++) begin
            @(negedge clk);
            check("vec_val", val8, v.vld[i]);
            check("vec_busy", busy8, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("vec_done", done8, 1'b1);
        check("vec_busy_end", busy8, 1'b0);
        check("vec_val_end", val8, 1'b0);
        check("vec_count", cnt8, v.len);
        check("vec_sb_empty", q8.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{10'd4, 2'd0, 8'hFE, 2'd0, 16'h000F, 4};
        vecs[1] = '{10'd3, 2'd0, 8'h00, 2'd2, 16'h0049, 7};
        vecs[2] = '{10'd5, 2'd1, 8'h00, 2'd1, 16'h0155, 9};
        vecs[3] = '{10'd3, 2'd3, 8'h10, 2'd3, 16'h0111, 9};
        vecs[4] = '{10'd2, 2'd2, 8'hA5, 2'd0, 16'h0003, 2};
        vecs[5] = '{10'd1, 2'd0, 8'h77, 2'd3, 16'h0001, 1};
        vecs[6] = '{10'd0, 2'd0, 8'h33, 2'd0, 16'h0000, 0};

        rst_n = 1'b0;
        en8 = 1'b1; start8 = 1'b0; rdy8 = 1'b1; len8 = '0; mode8 = '0; seed8 = '0; gap8 = '0;
        en16 = 1'b1; start16 = 1'b0; rdy16 = 1'b1; len16 = '0; mode16 = '0; seed16 = '0; gap16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_val8", val8, 1'b0);
        check("rst_data8", data8, 8'h00);
        check("rst_cnt8", cnt8, 10'd0);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_val16", val16, 1'b0);
        check("rst_data16", data16, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Stall: src_rdy low for 5 cycles with the first word on the bus.
        @(posedge clk); #1;
        len8 = 10'd3; mode8 = 2'd2; seed8 = 8'h5A; gap8 = 2'd0; rdy8 = 1'b0;
        push8(10'd3, 2'd2, 8'h5A);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_val", val8, 1'b1);
            check("stall_data", data8, 8'h5A);
            check("stall_cnt", cnt8, 10'd0);
            @(posedge clk); #1;
        end
        rdy8 = 1'b1;
        wait_done8(20);
        check("stall_count", cnt8, 10'd3);
        check("stall_sb_empty", q8.size(), 0);

        // Enable drop after two transfers, then a start attempt while SEND.
        @(posedge clk); #1;
        len8 = 10'd6; mode8 = 2'd0; seed8 = 8'h10; gap8 = 2'd0; rdy8 = 1'b1;
        push8(10'd6, 2'd0, 8'h10);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        en8 = 1'b0;
        @(posedge clk); #1;
        repeat (4) begin
            @(negedge clk);
            check("dis_val", val8, 1'b0);
            check("dis_cnt", cnt8, 10'd2);
            check("dis_data", data8, 8'h12);
            check("dis_busy", busy8, 1'b1);
            @(posedge clk); #1;
        end
        en8 = 1'b1; start8 = 1'b1; len8 = 10'd2; seed8 = 8'hEE;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        check("resume_val", val8, 1'b1);
        check("resume_data", data8, 8'h12);
        wait_done8(30);
        check("dis_count", cnt8, 10'd6);
        check("dis_sb_empty", q8.size(), 0);

        // Reset in the middle of a stream.
        @(posedge clk); #1;
        len8 = 10'd10; mode8 = 2'd0; seed8 = 8'h40; gap8 = 2'd0; rdy8 = 1'b1;
        push8(10'd10, 2'd0, 8'h40);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("mrst_val", val8, 1'b0);
        check("mrst_data", data8, 8'h00);
        check("mrst_cnt", cnt8, 10'd0);
        check("mrst_busy", busy8, 1'b0);
        check("mrst_done", done8, 1'b0);
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_busy", busy8, 1'b0);
        check("idle_done", done8, 1'b0);
        check("idle_val", val8, 1'b0);
        @(posedge clk); #1;
        len8 = 10'd2; mode8 = 2'd0; seed8 = 8'h20;
        push8(10'd2, 2'd0, 8'h20);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(10);
        check("post_rst_count", cnt8, 10'd2);
        check("post_rst_sb_empty", q8.size(), 0);

        // 16-bit LFSR with zero seed, 100 words.
        @(posedge clk); #1;
        len16 = 10'd100; mode16 = 2'd1; seed16 = 16'h0000; gap16 = 2'd0; rdy16 = 1'b1;
        push16_lfsr(100, 16'h0000);
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        @(negedge clk);
        check("lfsr16_first", data16, 16'h0001);
        check("lfsr16_val", val16, 1'b1);
        begin
            int n;
            n = 0;
            while (!done16 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("lfsr16_done", done16, 1'b1);
        check("lfsr16_count", cnt16, 10'd100);
        check("lfsr16_sb_empty", q16.size(), 0);
        check("lfsr16_distinct", seen16.num(), 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/master_vldrdy.md
# master_vldrdy

Source (transmitter) end of the team's valid/ready stream interface: generates a programmable-length data stream of DWIDTH-bit words on src_val/src_rdy/src_data and drives the word counter that the sink-side checker compares against its own write count. It sits opposite a valid/ready slave in stream benches. It is synthesizable RTL so the same stimulus source can also front real datapaths.

## Interface
- DWIDTH, 8, data width; legal values 8 and 16
- CWIDTH, 10, width of length and transfer counters
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active low
- cfg_en  in  1  enable, active high; protocol can be violated on disable
- cfg_start  in  1  start pulse, sampled when idle
- cfg_len  in  CWIDTH  number of words to send, latched on start
- cfg_mode  in  2  0 incrementing, 1 LFSR, 2 constant, 3 treated as 0
- cfg_seed  in  DWIDTH  first word / constant value, latched on start
- cfg_gap  in  2  idle cycles inserted after each accepted word (0-3), latched on start
- src_val  out  1  valid, active high
- src_rdy  in  1  ready, active high
- src_data  out  DWIDTH  data, steady while src_val high
- read_counter  out  CWIDTH  words accepted since last start
- busy  out  1  high in SEND or GAP
- done  out  1  high in DONE

## Operation
- FSM states: IDLE, SEND, GAP, DONE. Reset -> IDLE.
- IDLE/DONE: on cfg_en & cfg_start: latch len/mode/seed/gap, read_counter <= 0, src_data <= cfg_seed (seed 0 in LFSR mode replaced by 1); next state SEND, or DONE if cfg_len == 0.
- SEND: src_val = 1. Transfer = src_val & src_rdy at rising edge. On transfer: read_counter +1; if new count == len -> DONE; else if gap != 0 -> GAP (gap counter loaded); else stay SEND with next word.
- GAP: src_val = 0; count down latched gap; at zero -> SEND with next word already on src_data.
- Next word: mode 0 data+1 (wraps modulo 2^DWIDTH); mode 1 Fibonacci LFSR shift, taps 8,6,5,4 for DWIDTH 8, taps 16,14,13,11 for DWIDTH 16; mode 2 unchanged. Word advances only on transfer, never on stall.
- cfg_start in SEND/GAP ignored.
- cfg_en low: src_val forced 0, FSM, gap counter, data and read_counter frozen; on re-enable resumes in same state with same src_data.
- read_counter saturates at len; holds final value in DONE until next start.

## Timing
- All outputs registered. Reset values: src_val 0, src_data 0, read_counter 0, busy 0, done 0.
- Start accepted at edge N -> src_val high from cycle N+1, src_data = seed.
- gap 0: back-to-back, one word per cycle while src_rdy high.
- gap G: after transfer at edge N, src_val low cycles N+1..N+G, high again N+G+1.
- src_rdy low with src_val high: src_val and src_data held unchanged (stall), any duration.
- Last transfer at edge N -> src_val 0, done 1, busy 0, read_counter == len from cycle N+1.
- cfg_en drop at edge N -> src_val 0 from cycle N+1; the cycle of a drop with src_rdy high still counts a transfer at edge N.
- rst_n low mid-stream: all outputs to reset values immediately, FSM IDLE; no partial word counted.

## Structure
- Package vldrdy_pkg: state enum (IDLE, SEND, GAP, DONE), mode constants (MODE_INC, MODE_LFSR, MODE_CONST), LFSR tap constants per width.
- One sub-module: vldrdy_pattern_gen (holds src_data register, seed load, advance-on-transfer for the three modes). FSM, gap and transfer counters stay in top.

## Test plan
- Reset then cfg_len 4, mode 0, seed 8'hFE, gap 0, src_rdy tied 1 -> data FE,FF,00,01 on four consecutive cycles; done next cycle; read_counter 4.
- cfg_len 3, mode 2, seed 8'h5A, src_rdy low 5 cycles then high -> src_val held with 5A throughout stall; 3 transfers; read_counter 3.
- cfg_len 3, gap 2, mode 0, seed 0 -> src_val pattern 1,0,0,1,0,0,1 then 0; data 00,01,02.
- DWIDTH 16, mode 1, seed 0 -> first word 16'h0001; subsequent words match LFSR model; no repeat within 100 words.
- cfg_len 6, drop cfg_en after 2 transfers for 4 cycles -> src_val 0 during disable, resumes with word 3, final read_counter 6; cfg_start during SEND ignored.
- cfg_len 0 -> done next cycle, src_val never high; rst_n pulse mid-stream -> all outputs 0, IDLE.
